// File: rtl/axi4lite_wr_arbiter.sv
// Two-master, one-slave AXI4-Lite write-path arbiter with round-robin grant.
// Only one AW+W+B transaction is in flight at a time.
module axi4lite_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [2*ADDR_W-1:0]     m_awaddr,
    input  logic [1:0]              m_awvalid,
    output logic [1:0]              m_awready,
    input  logic [2*DATA_W-1:0]     m_wdata,
    input  logic [2*(DATA_W/8)-1:0] m_wstrb,
    input  logic [1:0]              m_wvalid,
    output logic [1:0]              m_wready,
    output logic [3:0]              m_bresp,
    output logic [1:0]              m_bvalid,
    input  logic [1:0]              m_bready,
    output logic [ADDR_W-1:0]       s_awaddr,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_W-1:0]       s_wdata,
    output logic [DATA_W/8-1:0]     s_wstrb,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic [1:0]              grant
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [1:0] r_grant;
    logic [1:0] w_grantNext;
    logic       r_last;
    logic       w_lastNext;
    logic       r_awDone;
    logic       w_awDoneNext;
    logic       r_wDone;
    logic       w_wDoneNext;
    logic       w_sel;
    logic       w_pick;

    assign w_sel = r_grant[1];
    assign grant = r_grant;

    // Payload is steered by the owner index; valids gate whether the slave acts on it.
    assign s_awaddr = w_sel ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    assign s_wdata  = w_sel ? m_wdata[2*DATA_W-1:DATA_W]  : m_wdata[DATA_W-1:0];
    assign s_wstrb  = w_sel ? m_wstrb[2*STRB_W-1:STRB_W]  : m_wstrb[STRB_W-1:0];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= IDLE;
            r_grant  <= 2'b00;
            r_last   <= 1'b1;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_grant  <= w_grantNext;
            r_last   <= w_lastNext;
            r_awDone <= w_awDoneNext;
            r_wDone  <= w_wDoneNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = r_grant;
        w_lastNext   = r_last;
        w_awDoneNext = r_awDone;
        w_wDoneNext  = r_wDone;
        w_pick       = 1'b0;
        s_awvalid    = 1'b0;
        s_wvalid     = 1'b0;
        s_bready     = 1'b0;
        m_awready    = 2'b00;
        m_wready     = 2'b00;
        m_bvalid     = 2'b00;
        m_bresp      = 4'b0000;

        case (r_state)
            IDLE: begin
                if (|m_awvalid) begin
                    // On a tie the master that did not win last time goes next.
                    w_pick      = (&m_awvalid) ? ~r_last : m_awvalid[1];
                    w_grantNext = w_pick ? 2'b10 : 2'b01;
                    w_lastNext  = w_pick;
                    w_stateNext = XFER;
                end
            end
            XFER: begin
                s_awvalid        = m_awvalid[w_sel] & ~r_awDone;
                m_awready[w_sel] = s_awready & ~r_awDone;
                s_wvalid         = m_wvalid[w_sel] & ~r_wDone;
                m_wready[w_sel]  = s_wready & ~r_wDone;
                w_awDoneNext     = r_awDone | (s_awvalid & s_awready);
                w_wDoneNext      = r_wDone | (s_wvalid & s_wready);
                if (w_awDoneNext && w_wDoneNext) begin
                    w_stateNext = RESP;
                end
            end
            RESP: begin
                s_bready                = m_bready[w_sel];
                m_bvalid[w_sel]         = s_bvalid;
                m_bresp[{w_sel, 1'b0} +: 2] = s_bresp;
                if (s_bvalid && s_bready) begin
                    w_awDoneNext = 1'b0;
                    w_wDoneNext  = 1'b0;
                    w_grantNext  = 2'b00;
                    w_stateNext  = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4lite_wr_arbiter.sv
// Directed bench for axi4lite_wr_arbiter: small master/slave behaviour models
// drive the ports each cycle, checks use hand-computed grant sequences and results.
module tb_axi4lite_wr_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [63:0] m_awaddr;
    logic [1:0]  m_awvalid;
    logic [1:0]  m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_wvalid;
    logic [1:0]  m_wready;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [1:0]  grant;

    axi4lite_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant)
    );

    always #5 ACLK = ~ACLK;

    // Master model state
    logic        awPend[2];
    logic        wPend[2];
    logic        autoRepeat[2];
    logic [31:0] mAddr[2];
    logic [31:0] mData[2];
    logic [3:0]  mStrb[2];
    int          bHold[2];
    int          bCount[2];
    logic [1:0]  lastBresp[2];

    // Slave model state
    int          awDelayCfg;
    int          awDelayCnt;
    logic [1:0]  respCode;
    logic        gotAw;
    logic        gotW;
    logic        bPend;
    logic [31:0] capAddr;
    logic [31:0] capData;
    logic [3:0]  capStrb;

    int vectors;
    int miscompares;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 2; i++) begin
            awPend[i] = 1'b0; wPend[i] = 1'b0; autoRepeat[i] = 1'b0;
            mAddr[i] = '0; mData[i] = '0; mStrb[i] = '0;
            bHold[i] = 0; bCount[i] = 0; lastBresp[i] = 2'b00;
        end
        awDelayCfg = 0; awDelayCnt = 0; respCode = 2'b00;
        gotAw = 1'b0; gotW = 1'b0; bPend = 1'b0;
        capAddr = '0; capData = '0; capStrb = '0;
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    endtask

    task automatic doReset();
        ARESETN = 1'b0;
        clearModel();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic startWrite(input int idx, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        mAddr[idx] = addr; mData[idx] = data; mStrb[idx] = strb;
        awPend[idx] = 1'b1; wPend[idx] = 1'b1;
    endtask

    // One clock cycle: drive from the models at the falling edge, then record handshakes.
    task automatic applyStimulus();
        @(negedge ACLK);
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = awPend[i];
            m_wvalid[i]  = wPend[i];
            m_bready[i]  = (bHold[i] == 0);
            m_awaddr[i*32 +: 32] = mAddr[i];
            m_wdata[i*32 +: 32]  = mData[i];
            m_wstrb[i*4 +: 4]    = mStrb[i];
        end
        s_awready = (awDelayCnt == 0);
        s_wready  = 1'b1;
        s_bvalid  = bPend;
        s_bresp   = bPend ? respCode : 2'b00;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_awvalid[i] && m_awready[i]) awPend[i] = 1'b0;
            if (m_wvalid[i] && m_wready[i]) wPend[i] = 1'b0;
            if (m_bvalid[i]) begin
                if (m_bready[i]) begin
                    bCount[i]++;
                    lastBresp[i] = m_bresp[i*2 +: 2];
                    if (autoRepeat[i]) begin
                        awPend[i] = 1'b1; wPend[i] = 1'b1;
                    end
                end else if (bHold[i] > 0) begin
                    bHold[i]--;
                end
            end
        end
        if (s_awvalid && s_awready) begin
            gotAw = 1'b1; capAddr = s_awaddr; awDelayCnt = awDelayCfg;
        end else if (s_awvalid && awDelayCnt > 0) begin
            awDelayCnt--;
        end
        if (s_wvalid && s_wready) begin
            gotW = 1'b1; capData = s_wdata; capStrb = s_wstrb;
        end
        if (s_bvalid && s_bready) bPend = 1'b0;
        if (gotAw && gotW && !bPend) begin
            bPend = 1'b1; gotAw = 1'b0; gotW = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] expGrant2[7];
        logic [1:0] rrSeen[4];
        logic [1:0] prevGrant;
        int leak, nGrants, mirror, stall, awWait;

        vectors = 0;
        miscompares = 0;

        // Reset holds every output low even with active inputs
        ARESETN = 1'b0;
        clearModel();
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b10;
        #2;
        checkOutput("reset outputs",
            {grant, s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, m_bresp}, 64'h0);
        doReset();

        $display("[TB] single write");
        startWrite(0, 32'h4, 32'hDEADBEEF, 4'hF);
        applyStimulus();
        checkOutput("t1 grant before", grant, 2'b00);
        applyStimulus();
        checkOutput("t1 grant", grant, 2'b01);
        checkOutput("t1 s_awvalid", s_awvalid, 1'b1);
        checkOutput("t1 s_awaddr", s_awaddr, 32'h4);
        applyStimulus();
        checkOutput("t1 m_bvalid", m_bvalid, 2'b01);
        applyStimulus();
        checkOutput("t1 grant after", grant, 2'b00);
        checkOutput("t1 slave addr", capAddr, 32'h4);
        checkOutput("t1 slave data", capData, 32'hDEADBEEF);
        checkOutput("t1 slave strb", capStrb, 4'hF);
        checkOutput("t1 bresp", lastBresp[0], 2'b00);
        checkOutput("t1 bcount", bCount[0], 1);

        $display("[TB] simultaneous request");
        doReset();
        expGrant2 = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        startWrite(0, 32'h8, 32'h11111111, 4'hF);
        startWrite(1, 32'hC, 32'h22222222, 4'h3);
        leak = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus();
            checkOutput($sformatf("t2 grant c%0d", k), grant, expGrant2[k]);
            if (grant == 2'b01 && m_awready[1]) leak++;
        end
        checkOutput("t2 m1 awready leak", leak, 0);
        checkOutput("t2 second addr", capAddr, 32'hC);
        checkOutput("t2 second strb", capStrb, 4'h3);
        checkOutput("t2 bcounts", {bCount[0][7:0], bCount[1][7:0]}, 16'h0101);

        $display("[TB] round robin");
        doReset();
        autoRepeat[0] = 1'b1; autoRepeat[1] = 1'b1;
        startWrite(0, 32'h20, 32'hA0A0A0A0, 4'hF);
        startWrite(1, 32'h24, 32'hB1B1B1B1, 4'hF);
        rrSeen = '{2'b00, 2'b00, 2'b00, 2'b00};
        nGrants = 0;
        prevGrant = 2'b00;
        for (int k = 0; k < 40 && nGrants < 4; k++) begin
            applyStimulus();
            if (grant != 2'b00 && prevGrant == 2'b00) begin
                rrSeen[nGrants] = grant;
                nGrants++;
            end
            prevGrant = grant;
        end
        checkOutput("t3 grant 0", rrSeen[0], 2'b01);
        checkOutput("t3 grant 1", rrSeen[1], 2'b10);
        checkOutput("t3 grant 2", rrSeen[2], 2'b01);
        checkOutput("t3 grant 3", rrSeen[3], 2'b10);

        $display("[TB] W before AW");
        doReset();
        mAddr[1] = 32'h30; mData[1] = 32'hCAFEF00D; mStrb[1] = 4'h5;
        wPend[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput($sformatf("t4 idle c%0d", k), {grant, s_wvalid}, 3'b000);
        end
        awPend[1] = 1'b1;
        applyStimulus();
        checkOutput("t4 grant latency", {grant, s_wvalid}, 3'b000);
        applyStimulus();
        checkOutput("t4 granted", {grant, s_wvalid}, 3'b101);
        for (int k = 0; k < 10 && bCount[1] == 0; k++) applyStimulus();
        repeat (3) applyStimulus();
        checkOutput("t4 single b", bCount[1], 1);
        checkOutput("t4 slave data", capData, 32'hCAFEF00D);

        $display("[TB] error and backpressure");
        doReset();
        respCode = 2'b10;
        awDelayCfg = 2; awDelayCnt = 2;
        bHold[1] = 3;
        startWrite(1, 32'h40, 32'h0BADBEEF, 4'hC);
        mirror = 0; stall = 0; awWait = 0;
        for (int k = 0; k < 30 && bCount[1] == 0; k++) begin
            applyStimulus();
            if (s_bvalid && (s_bready != m_bready[1])) mirror++;
            if (s_bvalid && !s_bready) stall++;
            if (grant == 2'b10 && s_awvalid && !s_awready) awWait++;
        end
        checkOutput("t5 bcount", bCount[1], 1);
        checkOutput("t5 bresp", lastBresp[1], 2'b10);
        checkOutput("t5 bready mirror", mirror, 0);
        checkOutput("t5 b stall cycles", stall, 3);
        checkOutput("t5 aw wait cycles", awWait, 2);
        checkOutput("t5 slave addr", capAddr, 32'h40);

        $display("[TB] reset mid-operation");
        doReset();
        bHold[0] = 5;
        startWrite(0, 32'h50, 32'h12345678, 4'hF);
        for (int k = 0; k < 10 && m_bvalid[0] == 1'b0; k++) applyStimulus();
        checkOutput("t6 in resp", m_bvalid, 2'b01);
        #1 ARESETN = 1'b0;
        #1;
        checkOutput("t6 async reset",
            {grant, s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, m_bresp}, 64'h0);
        doReset();
        startWrite(0, 32'h60, 32'h1, 4'h1);
        startWrite(1, 32'h64, 32'h2, 4'h2);
        applyStimulus();
        applyStimulus();
        checkOutput("t6 tie after reset", grant, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
